// File: rtl/dram_cmd_issuer.sv
// ---------------------------------------------------------------------------
// dram_cmd_issuer
//
// Purpose:
//   This block reads the head of the memory request queue and consumes it. It
//   decodes the byte address into bank group, bank, row and column. It then
//   issues one closed-page DRAM command sequence per request: ACT, then RD or
//   WR, then PRE. The gap between commands is counted in clk cycles. Requests
//   are handled strictly one at a time and in order.
//
// Handshake:
//   The queue head moves across when req_valid && req_ready are both high at a
//   rising clk edge, and only then. req_ready is combinational: it is high only
//   in IDLE and only once the free-running cycle counter has reached the
//   request's arrival time. The head is consumed exactly once. req_valid may
//   drop at any time and is ignored outside IDLE.
//
// Ports:
//   clk        in   DRAM command clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   req_valid  in   queue head holds a valid request
//   req_time   in   head request arrival time (clk cycles)
//   req_op     in   0=read, 1=write, 2=instruction fetch, others illegal
//   req_addr   in   byte address
//   req_ready  out  head is popped this cycle if req_valid is also high
//   cmd_valid  out  one-cycle command strobe
//   cmd_code   out  0=NOP 1=ACT 2=RD 3=WR 4=PRE
//   cmd_bg     out  bank group addr[7:6]
//   cmd_bank   out  bank addr[9:8]
//   cmd_row    out  row addr[31:17]
//   cmd_col    out  column {addr[16:10], addr[5:3]}
//   busy       out  high in every state except IDLE
//   op_err     out  one-cycle pulse after an illegal opcode is popped
//   dbg_state  out  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module dram_cmd_issuer #(
    parameter int TIME_W  = 100,
    parameter int T_RCD   = 24,
    parameter int T_RP    = 24,
    parameter int T_RTP   = 12,
    parameter int T_CWL   = 20,
    parameter int T_BURST = 4,
    parameter int T_WR    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [TIME_W-1:0] req_time,
    input  logic [31:0]       req_op,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic              cmd_valid,
    output logic [2:0]        cmd_code,
    output logic [1:0]        cmd_bg,
    output logic [1:0]        cmd_bank,
    output logic [14:0]       cmd_row,
    output logic [9:0]        cmd_col,
    output logic              busy,
    output logic              op_err,
    output logic [2:0]        dbg_state
);

    localparam int CW = 16;

    // The down-counter is loaded with (spacing - 1) in the command cycle, so
    // the next command goes out exactly `spacing` cycles later.
    localparam logic [CW-1:0] LD_RCD  = CW'(T_RCD - 1);
    localparam logic [CW-1:0] LD_RTP  = CW'(T_RTP - 1);
    localparam logic [CW-1:0] LD_WPRE = CW'(T_CWL + T_BURST + T_WR - 1);
    localparam logic [CW-1:0] LD_RP   = CW'(T_RP - 1);

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACT      = 3'd1,
        S_WAIT_RCD = 3'd2,
        S_CAS      = 3'd3,
        S_WAIT_PRE = 3'd4,
        S_PRE      = 3'd5,
        S_WAIT_RP  = 3'd6
    } state_t;

    state_t            state_q;
    logic [TIME_W-1:0] cyc_q;
    logic [TIME_W-1:0] cyc_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_dec;
    logic              is_wr_q;
    logic              cmd_valid_q;
    logic [2:0]        cmd_code_q;
    logic [1:0]        bg_q;
    logic [1:0]        bank_q;
    logic [14:0]       row_q;
    logic [9:0]        col_q;
    logic              op_err_q;
    logic              accept;
    logic              unused_addr_bits;

    // The address bits below the burst granule do not select anything.
    assign unused_addr_bits = ^req_addr[2:0];

    assign cyc_d   = cyc_q + 1'b1;
    assign cnt_dec = cnt_q - 1'b1;

    assign req_ready = (state_q == S_IDLE) && (cyc_q >= req_time);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= C_NOP;
            bg_q        <= '0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            op_err_q    <= 1'b0;
        end else begin
            cyc_q       <= cyc_d;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= C_NOP;
            op_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        bg_q    <= req_addr[7:6];
                        bank_q  <= req_addr[9:8];
                        row_q   <= req_addr[31:17];
                        col_q   <= {req_addr[16:10], req_addr[5:3]};
                        is_wr_q <= (req_op == 32'd1);
                        if (req_op > 32'd2) begin
                            // Illegal request: drop it, flag it, stay idle.
                            op_err_q <= 1'b1;
                        end else begin
                            state_q     <= S_ACT;
                            cmd_valid_q <= 1'b1;
                            cmd_code_q  <= C_ACT;
                            cnt_q       <= LD_RCD;
                        end
                    end
                end
                S_ACT, S_WAIT_RCD: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_CAS;
                        cmd_valid_q <= 1'b1;
                        cmd_code_q  <= is_wr_q ? C_WR : C_RD;
                        cnt_q       <= is_wr_q ? LD_WPRE : LD_RTP;
                    end else begin
                        state_q <= S_WAIT_RCD;
                        cnt_q   <= cnt_dec;
                    end
                end
                S_CAS, S_WAIT_PRE: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_PRE;
                        cmd_valid_q <= 1'b1;
                        cmd_code_q  <= C_PRE;
                        cnt_q       <= LD_RP;
                    end else begin
                        state_q <= S_WAIT_PRE;
                        cnt_q   <= cnt_dec;
                    end
                end
                S_PRE, S_WAIT_RP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT_RP;
                        cnt_q   <= cnt_dec;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_bg    = bg_q;
    assign cmd_bank  = bank_q;
    assign cmd_row   = row_q;
    assign cmd_col   = col_q;
    assign busy      = (state_q != S_IDLE);
    assign op_err    = op_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_dram_cmd_issuer
// Two instances share one stimulus: u_dut uses the default timing and u_fast
// uses T_RCD=T_RP=T_RTP=1. The `sel` signal picks which instance is checked.
// The reference model works per request, at the level of cycle numbers. When
// a request is accepted at cycle N it computes the cycles for ACT, CAS and PRE
// and the cycle at which the issuer is free again. It puts the expected
// commands on exp_q, and each cycle it compares every output against what the
// model predicts for that cycle.
// ---------------------------------------------------------------------------
module tb_dram_cmd_issuer;
  localparam int TW = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic [TW-1:0] req_time  = '0;
  logic [31:0]   req_op    = '0;
  logic [31:0]   req_addr  = '0;

  logic a_ready, a_cv, a_busy, a_err;
  logic [2:0] a_code, a_dbg;
  logic [1:0] a_bg, a_bank;
  logic [14:0] a_row;
  logic [9:0] a_col;
  logic b_ready, b_cv, b_busy, b_err;
  logic [2:0] b_code, b_dbg;
  logic [1:0] b_bg, b_bank;
  logic [14:0] b_row;
  logic [9:0] b_col;

  dram_cmd_issuer u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_time(req_time),
    .req_op(req_op), .req_addr(req_addr), .req_ready(a_ready),
    .cmd_valid(a_cv), .cmd_code(a_code), .cmd_bg(a_bg), .cmd_bank(a_bank),
    .cmd_row(a_row), .cmd_col(a_col), .busy(a_busy), .op_err(a_err),
    .dbg_state(a_dbg)
  );

  dram_cmd_issuer #(.T_RCD(1), .T_RP(1), .T_RTP(1)) u_fast (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_time(req_time),
    .req_op(req_op), .req_addr(req_addr), .req_ready(b_ready),
    .cmd_valid(b_cv), .cmd_code(b_code), .cmd_bg(b_bg), .cmd_bank(b_bank),
    .cmd_row(b_row), .cmd_col(b_col), .busy(b_busy), .op_err(b_err),
    .dbg_state(b_dbg)
  );

  logic sel = 1'b0;
  logic o_ready, o_cv, o_busy, o_err;
  logic [2:0] o_code;
  logic [28:0] o_fields;
  assign o_ready  = sel ? b_ready : a_ready;
  assign o_cv     = sel ? b_cv    : a_cv;
  assign o_busy   = sel ? b_busy  : a_busy;
  assign o_err    = sel ? b_err   : a_err;
  assign o_code   = sel ? b_code  : a_code;
  assign o_fields = sel ? {b_bg, b_bank, b_row, b_col} : {a_bg, a_bank, a_row, a_col};

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int          t;
    logic [31:0] op;
    logic [31:0] addr;
  } req_t;

  req_t        rq[$];
  logic [34:0] exp_q[$];   // {cycle, command code}
  int          ev_q[$];    // cycles at which the checked DUT strobed a command
  int          cyc;
  int          free_c;
  int          err_c;
  int          last_acc;
  logic [31:0] m_addr;
  int m_rcd = 24, m_rp = 24, m_rtp = 12, m_wpre = 20 + 4 + 20;
  bit auto_gen = 0, rand_valid = 0;
  int cur_t;
  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
  endtask

  function automatic logic [28:0] fields(input logic [31:0] a);
    return {a[7:6], a[9:8], a[31:17], a[16:10], a[5:3]};
  endfunction

  function automatic int get_ev(input int i);
    return (i < ev_q.size()) ? ev_q[i] : -1;
  endfunction

  task automatic push_req(input int t, input logic [31:0] op, input logic [31:0] addr);
    req_t r;
    r.t = t; r.op = op; r.addr = addr;
    rq.push_back(r);
  endtask

  task automatic push_rand();
    int r, t;
    logic [31:0] op;
    r = $urandom_range(0, 9);
    if (r <= 2) op = 32'd0;
    else if (r <= 5) op = 32'd1;
    else if (r <= 7) op = 32'd2;
    else op = $urandom_range(3, 32'hFFFF_FFFF);
    if ($urandom_range(0, 1) == 1) t = cyc + $urandom_range(0, 50);
    else t = (cyc >= 20) ? cyc - $urandom_range(0, 20) : 0;
    push_req(t, op, $urandom);
  endtask

  task automatic model_clear();
    rq.delete(); exp_q.delete(); ev_q.delete();
    free_c = 0; err_c = -1; last_acc = -1; m_addr = '0; cyc = 0;
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_time = TW'(1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, update model, advance.
  task automatic run_cycle();
    logic e_busy, e_ready, acc;
    logic [2:0] e_code;
    int act, cas, pre;
    req_t h;
    if (auto_gen && rq.size() == 0 && $urandom_range(0, 2) == 0) push_rand();
    if (rq.size() > 0) begin
      cur_t = rq[0].t;
      req_op = rq[0].op;
      req_addr = rq[0].addr;
      req_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      cur_t = cyc + $urandom_range(0, 3);
      req_op = $urandom;
      req_addr = $urandom;
      req_valid = 1'b0;
    end
    req_time = TW'(cur_t);
    @(negedge clk);
    e_busy = (cyc < free_c);
    e_ready = !e_busy && (cyc >= cur_t);
    e_code = 3'd0;
    if (exp_q.size() > 0 && exp_q[0][34:3] == cyc[31:0]) begin
      e_code = exp_q[0][2:0];
      void'(exp_q.pop_front());
    end
    chk("req_ready", 64'(o_ready), 64'(e_ready));
    chk("busy", 64'(o_busy), 64'(e_busy));
    chk("cmd_valid", 64'(o_cv), 64'(e_code != 3'd0));
    chk("cmd_code", 64'(o_code), 64'(e_code));
    chk("op_err", 64'(o_err), 64'(cyc == err_c));
    chk("fields", 64'(o_fields), 64'(fields(m_addr)));
    if (o_cv) ev_q.push_back(cyc);
    acc = req_valid && e_ready;
    if (acc) begin
      h = rq.pop_front();
      m_addr = h.addr;
      last_acc = cyc;
      if (h.op > 32'd2) begin
        err_c = cyc + 1;
      end else begin
        act = cyc + 1;
        cas = act + m_rcd;
        pre = cas + ((h.op == 32'd1) ? m_wpre : m_rtp);
        free_c = pre + m_rp;
        exp_q.push_back({act, 3'd1});
        exp_q.push_back({cas, (h.op == 32'd1) ? 3'd3 : 3'd2});
        exp_q.push_back({pre, 3'd4});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    auto_gen = 0;
    for (int i = 0; i < 400 && !(rq.size() == 0 && cyc >= free_c); i++) run_cycle();
    chk("drain_idle", 64'(rq.size() == 0 && cyc >= free_c), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc_before;
    do_reset();
    // Reset state, checked before any stimulus.
    chk("rst_cmd_valid", 64'(a_cv), 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));

    // Directed: read, write, late arrival, ifetch, illegal op.
    push_req(0, 32'd0, 32'h0006_03C0);
    push_req(0, 32'd1, 32'h0006_03C0);
    push_req(500, 32'd0, 32'h1234_5678);
    push_req(0, 32'd2, 32'h8765_4321);
    push_req(0, 32'd7, 32'hDEAD_BEEF);
    while (cyc < 650) run_cycle();
    chk("rd_act", 64'(get_ev(0)), 64'(1));
    chk("rd_cas", 64'(get_ev(1)), 64'(25));
    chk("rd_pre", 64'(get_ev(2)), 64'(37));
    chk("wr_act", 64'(get_ev(3)), 64'(62));
    chk("wr_cas", 64'(get_ev(4)), 64'(86));
    chk("wr_pre", 64'(get_ev(5)), 64'(130));
    chk("late_act", 64'(get_ev(6)), 64'(501));
    chk("if_cas", 64'(get_ev(10)), 64'(586));
    chk("illegal_no_cmd", 64'(ev_q.size()), 64'(12));
    chk("illegal_acc", 64'(last_acc), 64'(622));

    // Randomized traffic against the model.
    auto_gen = 1; rand_valid = 1;
    repeat (3000) run_cycle();
    drain();

    // Reset in the middle of a write.
    rand_valid = 0;
    push_req(0, 32'd1, $urandom);
    acc_before = last_acc;
    for (int i = 0; i < 300 && last_acc == acc_before; i++) run_cycle();
    chk("wr_accepted", 64'(last_acc != acc_before), 64'(1));
    repeat (30) run_cycle();
    req_valid = 1'b0;
    req_time = TW'(1);
    rst = 1'b1;
    #1;
    chk("midrst_cmd_valid", 64'(o_cv), 64'(0));
    chk("midrst_code", 64'(o_code), 64'(0));
    chk("midrst_busy", 64'(o_busy), 64'(0));
    chk("midrst_fields", 64'(o_fields), 64'(0));
    chk("midrst_ready", 64'(o_ready), 64'(0));
    do_reset();
    push_req(0, 32'd1, $urandom);
    push_req(5, 32'd0, $urandom);
    repeat (200) run_cycle();
    chk("post_rst_act", 64'(get_ev(0)), 64'(1));
    chk("post_rst_no_pre", 64'(ev_q.size()), 64'(6));

    // Fast instance: unit spacings.
    sel = 1'b1;
    m_rcd = 1; m_rp = 1; m_rtp = 1;
    do_reset();
    push_req(0, 32'd0, 32'h0006_03C0);
    push_req(0, 32'd0, 32'h0000_0008);
    repeat (12) run_cycle();
    chk("fast_act", 64'(get_ev(0)), 64'(1));
    chk("fast_rd", 64'(get_ev(1)), 64'(2));
    chk("fast_pre", 64'(get_ev(2)), 64'(3));
    chk("fast_next_act", 64'(get_ev(3)), 64'(5));
    auto_gen = 1; rand_valid = 1;
    repeat (1500) run_cycle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
